// File: rtl/pe_dot_accum_if.sv
// Activation stream in, dot-product result out over valid/ready.
// master = upstream/downstream side, slave = pe_dot_accum.
interface pe_dot_accum_if #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 24
);
  logic                    in_start;
  logic signed [DW-1:0]    in_data;
  logic        [AW-1:0]    in_addr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  modport master (
    output in_start, in_data, in_addr, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_start, in_data, in_addr, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/pe_dot_accum.sv
// Serial 32-element dot product against a local weight file; result after 33 cycles, held until out_ready.
// Optional macro PE_DOT_RELU_EN clamps the captured result at zero (accumulation stays raw).
module pe_dot_accum #(
  parameter int N     = 32,
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  pe_dot_accum_if.slave        s,
  input  logic                 wt_we,
  input  logic [AW-1:0]        wt_waddr,
  input  logic signed [DW-1:0] wt_wdata,
  output logic                 busy,
  output logic                 err_addr,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t                  state;
  logic signed [DW-1:0]    weights [N];
  logic signed [DW-1:0]    wt_rd;
  logic        [AW-1:0]    cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] result_val;
  logic signed [2*DW-1:0]  prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) weights[i] <= '0;
    end else if (wt_we) begin
      weights[wt_waddr] <= wt_wdata;
    end
  end

  // Same-cycle write to the addressed weight is not visible until the next cycle.
  always_comb begin
    wt_rd    = weights[s.in_addr];
    prod     = $signed({{DW{s.in_data[DW-1]}}, s.in_data}) * $signed({{DW{wt_rd[DW-1]}}, wt_rd});
    acc_next = ((cnt == '0) ? '0 : acc) + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
`ifdef PE_DOT_RELU_EN
    result_val = acc_next[ACC_W-1] ? '0 : acc_next;
`else
    result_val = acc_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      busy        <= 1'b0;
      err_addr    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.in_start) begin
            state <= ACCUM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          // A new start aborts the frame; cnt==0 makes the next element ignore stale acc.
          if (s.in_start) begin
            cnt <= '0;
          end else begin
            if (s.in_addr != cnt) err_addr <= 1'b1;
            acc <= acc_next;
            if (cnt == AW'(N-1)) begin
              state       <= RESULT;
              s.out_data  <= result_val;
              s.out_valid <= 1'b1;
              busy        <= 1'b0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        RESULT: begin
          if (s.in_start) begin
            if (!s.out_ready) err_overrun <= 1'b1;
            state       <= ACCUM;
            cnt         <= '0;
            s.out_valid <= 1'b0;
            busy        <= 1'b1;
          end else if (s.out_ready) begin
            state       <= IDLE;
            s.out_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          s.out_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
